hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- HI/LO register file for the EX stage; consumes quotient/remainder from the 16-stage pipelined DIV unit, plus multiplier and MTHI/MTLO writes.
- Tracks in-flight divides with a token FIFO; flushed divides are discarded on return.
- Stalls MFHI/MFLO and other HI/LO writes until all live divides have written back.

Parameters:
- DATA_W, 32, HI/LO and operand width
- MAX_INFLIGHT, 4, token FIFO depth (max outstanding divides), power of 2
- CNT_W, 3, width of occupancy counters; must hold 0..MAX_INFLIGHT

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- flush  in  1  pipeline flush; kills every divide currently in flight
- div_issue  in  1  divide entering DIV this cycle
- div_ready  out  1  token FIFO can accept an issue
- div_done  in  1  DIV result valid (DIV CE_out)
- quotient_in  in  DATA_W  DIV quotient
- remainder_in  in  DATA_W  DIV remainder
- mul_we  in  1  multiplier writes HI/LO
- mul_hi, mul_lo  in  DATA_W  multiplier result
- mthi_we, mtlo_we  in  1  MTHI/MTLO write strobes
- mt_data  in  DATA_W  MTHI/MTLO source
- rd_hi, rd_lo  in  1  MFHI/MFLO read request
- hi_out, lo_out  out  DATA_W  HI/LO read data
- hilo_stall  out  1  stall request to EX
- pending_cnt  out  CNT_W  FIFO occupancy (live + killed)
- err_underflow  out  1  sticky: div_done seen with FIFO empty

Behaviour:
- Reset (async, any time, including mid-divide): HI=LO=0, FIFO empty, live_cnt=0, err_underflow=0, outputs follow.
- Token FIFO: 1 bit per entry ("live"), circular with rd/wr pointers that wrap modulo MAX_INFLIGHT.
- Push on div_issue && div_ready && !flush, with live=1. div_issue during flush is ignored.
- div_ready = pending_cnt < MAX_INFLIGHT, registered-count based. A pop in the same cycle does not raise it.
- Pop on div_done when FIFO is non-empty. Push and pop together leave the count unchanged.
- div_done with an empty FIFO: no pop, no write, err_underflow set until reset.
- Popped entry live: next edge LO<=quotient_in, HI<=remainder_in, live_cnt decrements.
- Popped entry killed: result discarded.
- flush clears live bits of all current entries and sets live_cnt=0. Entries stay until popped, because the DIV still returns them.
- flush together with div_done: the popped entry is treated as killed.
- Divide by zero is not detected; whatever DIV returns is written.
- hilo_stall = (live_cnt!=0) && (rd_hi | rd_lo | mul_we | mthi_we | mtlo_we). Combinational from registered live_cnt.
- While hilo_stall=1, mul/mt writes are ignored.
- Write priority when not stalled: mul_we (HI<=mul_hi, LO<=mul_lo) overrides mthi_we/mtlo_we, which write independently.
- A killed-divide pop in the same cycle never writes.
- hi_out/lo_out = registered HI/LO. Writes become visible the cycle after the edge.

Optional Feature:
- HILO_BYPASS_EN defined:
  - When live_cnt==1 and div_done pops a live entry, the stall is removed for rd_hi/rd_lo that cycle.
  - hi_out=remainder_in and lo_out=quotient_in are forwarded combinationally.
  - Write requests still stall that cycle.
- Undefined: no forwarding; reads stall until the cycle after writeback.

Decomposition:
- Shared header: DATA_W default, MAX_INFLIGHT default, HI/LO reset value.
- One sub-module, div_token_fifo: 1-bit live FIFO with push/pop/kill_all, count, and live_cnt outputs.
- hilo_unit holds the registers, stall logic and bypass.

Test Plan:
- Single divide: issue 6/2, div_done 16 cycles later with q=3, r=0 → LO=3, HI=0 next cycle; rd_lo stalls throughout and releases after writeback.
- Four back-to-back issues → div_ready=0 at count 4; fifth issue rejected; four pops restore div_ready=1, pending_cnt=0.
- Issue 8/2, flush 5 cycles later, div_done returns q=4 → HI/LO unchanged, live_cnt=0 right after flush, rd_hi never stalls after flush.
- mul_we with HI=0x1, LO=0x2 and mthi_we=1, mt_data=0xFF same cycle, no divides → HI=0x1, LO=0x2.
- div_done with empty FIFO → err_underflow=1 and held; reset asserted mid-divide → all outputs 0 asynchronously.
- HILO_BYPASS_EN: live_cnt=1, div_done q=5, r=1 with rd_lo=1 → hilo_stall=0, lo_out=5 that cycle. Without the macro → stall=1, lo_out=5 next cycle.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: default widths, FIFO depth, reset value
// and the write-source selector used by the register update logic.
package hilo_unit_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int CNT_W_DEF        = 3;

  // HI/LO come out of reset as all copies of this bit.
  localparam logic HILO_RST_BIT = 1'b0;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_DIV  = 2'd1,
    WR_MUL  = 2'd2,
    WR_MT   = 2'd3
  } hilo_wr_src_e;

endpackage

// File: rtl/hilo_if.sv
// EX-stage bus to the HI/LO unit: divide token handshake, DIV results,
// multiplier and MTHI/MTLO writes, MFHI/MFLO reads and status.
interface hilo_if import hilo_unit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              flush;
  logic              div_issue;
  logic              div_ready;
  logic              div_done;
  logic [DATA_W-1:0] quotient_in;
  logic [DATA_W-1:0] remainder_in;
  logic              mul_we;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;
  logic              mthi_we;
  logic              mtlo_we;
  logic [DATA_W-1:0] mt_data;
  logic              rd_hi;
  logic              rd_lo;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              hilo_stall;
  logic [CNT_W-1:0]  pending_cnt;
  logic              err_underflow;

  modport master (
    output flush, div_issue, div_done, quotient_in, remainder_in,
           mul_we, mul_hi, mul_lo, mthi_we, mtlo_we, mt_data, rd_hi, rd_lo,
    input  div_ready, hi_out, lo_out, hilo_stall, pending_cnt, err_underflow
  );

  modport slave (
    input  flush, div_issue, div_done, quotient_in, remainder_in,
           mul_we, mul_hi, mul_lo, mthi_we, mtlo_we, mt_data, rd_hi, rd_lo,
    output div_ready, hi_out, lo_out, hilo_stall, pending_cnt, err_underflow
  );
endinterface

// File: rtl/hilo_unit_div_token_fifo.sv
// One-bit token FIFO tracking in-flight divides. Each entry records whether the
// divide is still live; kill_all clears every live bit but keeps the entries.
module div_token_fifo import hilo_unit_pkg::*; #(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             kill_all,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] live_cnt,
  output logic             empty,
  output logic             full,
  output logic             head_live
);

  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [MAX_INFLIGHT-1:0] live_r;
  logic [MAX_INFLIGHT-1:0] live_nxt_s;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        count_nxt_s;
  logic [CNT_W-1:0]        live_cnt_r;
  logic [CNT_W-1:0]        live_cnt_nxt_s;
  logic                    pop_live_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(MAX_INFLIGHT));
  // A flush in the same cycle as the pop turns the head into a killed entry.
  assign head_live = live_r[rd_ptr_r] & ~kill_all;
  assign pop_live_s = pop & head_live;
  assign count     = count_r;
  assign live_cnt  = live_cnt_r;

  // Next live bits; push and pop never target the same slot (full/empty).
  always_comb begin
    live_nxt_s = live_r;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (kill_all) begin
        live_nxt_s[i] = 1'b0;
      end else if (push && (wr_ptr_r == PTR_W'(i))) begin
        live_nxt_s[i] = 1'b1;
      end else if (pop && (rd_ptr_r == PTR_W'(i))) begin
        live_nxt_s[i] = 1'b0;
      end else begin
        live_nxt_s[i] = live_r[i];
      end
    end
  end

  // Occupancy and live counters.
  always_comb begin
    count_nxt_s    = count_r;
    live_cnt_nxt_s = live_cnt_r;
    case ({push, pop})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    if (kill_all) begin
      live_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      case ({push, pop_live_s})
        2'b10:   live_cnt_nxt_s = live_cnt_r + CNT_W'(1);
        2'b01:   live_cnt_nxt_s = live_cnt_r - CNT_W'(1);
        default: live_cnt_nxt_s = live_cnt_r;
      endcase
    end
  end

  // FIFO state registers; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_r     <= {MAX_INFLIGHT{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      live_cnt_r <= {CNT_W{1'b0}};
    end else begin
      live_r     <= live_nxt_s;
      rd_ptr_r   <= pop  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      wr_ptr_r   <= push ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      count_r    <= count_nxt_s;
      live_cnt_r <= live_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file for EX: divide writeback via token FIFO, multiplier and
// MTHI/MTLO writes, stall generation. Optional read forwarding: HILO_BYPASS_EN.
module hilo_unit import hilo_unit_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic   clk,
  input  logic   reset,
  hilo_if.slave  bus
);

  logic              push_s;
  logic              pop_s;
  logic              empty_s;
  logic              full_s;
  logic              head_live_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  live_cnt_s;
  logic              div_wr_s;
  logic              rd_req_s;
  logic              wr_req_s;
  logic              bypass_s;
  logic              stall_s;
  hilo_wr_src_e      wr_src_s;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic [DATA_W-1:0] hi_nxt_s;
  logic [DATA_W-1:0] lo_nxt_s;
  logic              err_r;

  assign push_s   = bus.div_issue & ~full_s & ~bus.flush;
  assign pop_s    = bus.div_done & ~empty_s;
  assign div_wr_s = pop_s & head_live_s;
  assign rd_req_s = bus.rd_hi | bus.rd_lo;
  assign wr_req_s = bus.mul_we | bus.mthi_we | bus.mtlo_we;

  div_token_fifo #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .kill_all  (bus.flush),
    .count     (count_s),
    .live_cnt  (live_cnt_s),
    .empty     (empty_s),
    .full      (full_s),
    .head_live (head_live_s)
  );

`ifdef HILO_BYPASS_EN
  // Last live divide returning now: reads can take the result directly.
  assign bypass_s = div_wr_s & (live_cnt_s == CNT_W'(1));
`else
  assign bypass_s = 1'b0;
`endif

  assign stall_s = (live_cnt_s != {CNT_W{1'b0}}) & (wr_req_s | (rd_req_s & ~bypass_s));

  // Select the write source; a live divide pop only happens while live_cnt != 0,
  // so any competing write request is already stalled.
  always_comb begin
    wr_src_s = WR_NONE;
    if (div_wr_s) begin
      wr_src_s = WR_DIV;
    end else if (stall_s) begin
      wr_src_s = WR_NONE;
    end else if (bus.mul_we) begin
      wr_src_s = WR_MUL;
    end else if (bus.mthi_we || bus.mtlo_we) begin
      wr_src_s = WR_MT;
    end else begin
      wr_src_s = WR_NONE;
    end
  end

  // Next HI/LO values for the chosen source.
  always_comb begin
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    case (wr_src_s)
      WR_DIV: begin
        hi_nxt_s = bus.remainder_in;
        lo_nxt_s = bus.quotient_in;
      end
      WR_MUL: begin
        hi_nxt_s = bus.mul_hi;
        lo_nxt_s = bus.mul_lo;
      end
      WR_MT: begin
        hi_nxt_s = bus.mthi_we ? bus.mt_data : hi_r;
        lo_nxt_s = bus.mtlo_we ? bus.mt_data : lo_r;
      end
      default: begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
      end
    endcase
  end

  // HI/LO registers and the sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r  <= {DATA_W{HILO_RST_BIT}};
      lo_r  <= {DATA_W{HILO_RST_BIT}};
      err_r <= 1'b0;
    end else begin
      hi_r  <= hi_nxt_s;
      lo_r  <= lo_nxt_s;
      err_r <= err_r | (bus.div_done & empty_s);
    end
  end

  assign bus.div_ready     = ~full_s;
  assign bus.pending_cnt   = count_s;
  assign bus.hilo_stall    = stall_s;
  assign bus.err_underflow = err_r;
  assign bus.hi_out        = bypass_s ? bus.remainder_in : hi_r;
  assign bus.lo_out        = bypass_s ? bus.quotient_in  : lo_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus randomized traffic
// compared against a queue-based model of divide tokens and HI/LO contents.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int DW = 32;
  localparam int MI = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: one entry per outstanding divide, 1 = still live.
  bit          m_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_err;

  always #5 clk = ~clk;

  hilo_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  hilo_unit #(.DATA_W(DW), .MAX_INFLIGHT(MI), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    foreach (m_q[i]) n += m_q[i];
    return n;
  endfunction

  task automatic idle();
    bus.flush = 1'b0; bus.div_issue = 1'b0; bus.div_done = 1'b0;
    bus.quotient_in = 32'd0; bus.remainder_in = 32'd0;
    bus.mul_we = 1'b0; bus.mul_hi = 32'd0; bus.mul_lo = 32'd0;
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.mt_data = 32'd0;
    bus.rd_hi = 1'b0; bus.rd_lo = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.flush        = ($urandom_range(15) == 0);
    bus.div_issue    = ($urandom_range(2) == 0);
    bus.div_done     = ($urandom_range(3) == 0);
    bus.quotient_in  = $urandom;
    bus.remainder_in = $urandom;
    bus.mul_we       = ($urandom_range(5) == 0);
    bus.mul_hi       = $urandom;
    bus.mul_lo       = $urandom;
    bus.mthi_we      = ($urandom_range(4) == 0);
    bus.mtlo_we      = ($urandom_range(4) == 0);
    bus.mt_data      = $urandom;
    bus.rd_hi        = ($urandom_range(3) == 0);
    bus.rd_lo        = ($urandom_range(3) == 0);
  endtask

  // Called at a falling edge with inputs driven: checks outputs, then advances one clock.
  task automatic step();
    int   live;
    bit   pop, plive, byp, rd_any, wr_any, st;
    logic [31:0] ehi, elo;
    #1;
    live   = live_count();
    rd_any = bus.rd_hi | bus.rd_lo;
    wr_any = bus.mul_we | bus.mthi_we | bus.mtlo_we;
    pop    = bus.div_done && (m_q.size() > 0);
    plive  = pop && m_q[0] && !bus.flush;
    byp    = 1'b0;
`ifdef HILO_BYPASS_EN
    byp    = (live == 1) && plive;
`endif
    st  = (live != 0) && (wr_any || (rd_any && !byp));
    ehi = byp ? bus.remainder_in : m_hi;
    elo = byp ? bus.quotient_in  : m_lo;
    check_val("pending_cnt", 32'(bus.pending_cnt), 32'(m_q.size()));
    check_val("div_ready", 32'(bus.div_ready), 32'(m_q.size() < MI));
    check_val("hilo_stall", 32'(bus.hilo_stall), 32'(st));
    check_val("hi_out", bus.hi_out, ehi);
    check_val("lo_out", bus.lo_out, elo);
    check_val("err_underflow", 32'(bus.err_underflow), 32'(m_err));
    @(posedge clk);
    if (plive) begin
      m_hi = bus.remainder_in;
      m_lo = bus.quotient_in;
    end else if (!st) begin
      if (bus.mul_we) begin
        m_hi = bus.mul_hi;
        m_lo = bus.mul_lo;
      end else begin
        if (bus.mthi_we) m_hi = bus.mt_data;
        if (bus.mtlo_we) m_lo = bus.mt_data;
      end
    end
    if (bus.div_done && m_q.size() == 0) m_err = 1'b1;
    if (bus.div_issue && m_q.size() < MI && !bus.flush) begin
      if (pop) void'(m_q.pop_front());
      if (bus.flush) foreach (m_q[i]) m_q[i] = 1'b0;
      m_q.push_back(1'b1);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (bus.flush) foreach (m_q[i]) m_q[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    check_val("rst_hi", bus.hi_out, 32'd0);
    check_val("rst_lo", bus.lo_out, 32'd0);
    check_val("rst_pending", 32'(bus.pending_cnt), 32'd0);
    check_val("rst_err", 32'(bus.err_underflow), 32'd0);
    check_val("rst_ready", 32'(bus.div_ready), 32'd1);
    m_q.delete();
    m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_divide(input logic [31:0] q, input logic [31:0] r, input bit rd);
    idle(); bus.div_issue = 1'b1; step();
    for (int i = 0; i < 15; i++) begin
      idle(); bus.rd_lo = rd; step();
    end
    idle(); bus.div_done = 1'b1; bus.quotient_in = q; bus.remainder_in = r; bus.rd_lo = rd;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(negedge clk);
    do_reset();

    // Single divide 6/2: reads stall until writeback, then LO=3, HI=0.
    run_divide(32'd3, 32'd0, 1'b0);
    step();
    idle(); bus.rd_lo = 1'b1; #1;
    check_val("div_lo", bus.lo_out, 32'd3);
    check_val("div_hi", bus.hi_out, 32'd0);
    check_val("div_rd_release", 32'(bus.hilo_stall), 32'd0);
    step();
    idle(); bus.div_issue = 1'b1; step();
    idle(); bus.rd_lo = 1'b1; #1;
    check_val("div_rd_stall", 32'(bus.hilo_stall), 32'd1);
    step();

    // Flush a divide in flight: its result must be discarded.
    do_reset();
    idle(); bus.mtlo_we = 1'b1; bus.mt_data = 32'd3; step();
    idle(); bus.div_issue = 1'b1; step();
    for (int i = 0; i < 4; i++) begin idle(); step(); end
    idle(); bus.flush = 1'b1; step();
    for (int i = 0; i < 10; i++) begin
      idle(); bus.rd_hi = 1'b1; #1;
      if (i == 0) check_val("flush_no_stall", 32'(bus.hilo_stall), 32'd0);
      step();
    end
    idle(); bus.div_done = 1'b1; bus.quotient_in = 32'd4; bus.remainder_in = 32'd0; bus.rd_hi = 1'b1; step();
    idle(); #1;
    check_val("flush_lo_kept", bus.lo_out, 32'd3);
    check_val("flush_pending", 32'(bus.pending_cnt), 32'd0);
    step();

    // Fill the token FIFO, reject a fifth issue, then drain.
    for (int i = 0; i < MI; i++) begin idle(); bus.div_issue = 1'b1; step(); end
    idle(); #1;
    check_val("full_ready", 32'(bus.div_ready), 32'd0);
    check_val("full_pending", 32'(bus.pending_cnt), 32'd4);
    bus.div_issue = 1'b1; step();
    for (int i = 0; i < MI; i++) begin
      idle(); bus.div_done = 1'b1; bus.quotient_in = 32'(i + 10); bus.remainder_in = 32'(i); step();
    end
    idle(); #1;
    check_val("drain_ready", 32'(bus.div_ready), 32'd1);
    check_val("drain_pending", 32'(bus.pending_cnt), 32'd0);
    check_val("drain_lo", bus.lo_out, 32'd13);

    // mul_we wins over a simultaneous MTHI.
    idle(); bus.mul_we = 1'b1; bus.mul_hi = 32'h1; bus.mul_lo = 32'h2;
    bus.mthi_we = 1'b1; bus.mt_data = 32'hFF; step();
    idle(); #1;
    check_val("mul_hi", bus.hi_out, 32'h1);
    check_val("mul_lo", bus.lo_out, 32'h2);

    // Last live divide returning while MFLO is requested.
    run_divide(32'd5, 32'd1, 1'b1);
    #1;
`ifdef HILO_BYPASS_EN
    check_val("byp_stall", 32'(bus.hilo_stall), 32'd0);
    check_val("byp_lo", bus.lo_out, 32'd5);
`else
    check_val("nobyp_stall", 32'(bus.hilo_stall), 32'd1);
    check_val("nobyp_lo", bus.lo_out, 32'h2);
`endif
    step();
    idle(); #1;
    check_val("wb_lo", bus.lo_out, 32'd5);
    check_val("wb_hi", bus.hi_out, 32'd1);

    // Underflow is sticky until reset; reset mid-divide clears everything.
    idle(); bus.div_done = 1'b1; step();
    for (int i = 0; i < 3; i++) begin idle(); step(); end
    idle(); #1;
    check_val("underflow_held", 32'(bus.err_underflow), 32'd1);
    idle(); bus.div_issue = 1'b1; step();
    for (int i = 0; i < 3; i++) begin idle(); step(); end
    do_reset();

    // Randomized traffic against the model.
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 500; i++) begin
        rand_inputs();
        step();
      end
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
